// File: rtl/mmio_pkg.sv
// Register map and bit assignments for the MEM-stage MMIO responder.
package mmio_pkg;

   // Byte offsets within the 32-byte register window
   localparam logic [4:0] OFF_PORT_OUT     = 5'h00;
   localparam logic [4:0] OFF_PORT_OUT_SET = 5'h04;
   localparam logic [4:0] OFF_PORT_OUT_CLR = 5'h08;
   localparam logic [4:0] OFF_PORT_IN      = 5'h0C;
   localparam logic [4:0] OFF_STATUS       = 5'h10;
   localparam logic [4:0] OFF_TIMER        = 5'h14;
   localparam logic [4:0] OFF_COMPARE      = 5'h18;
   localparam logic [4:0] OFF_CTRL         = 5'h1C;

   // STATUS bits
   localparam int unsigned STS_IN_CHG    = 0;
   localparam int unsigned STS_TMR_MATCH = 1;

   // CTRL bits
   localparam int unsigned CTRL_TMR_EN       = 0;
   localparam int unsigned CTRL_IRQ_EN_CHG   = 1;
   localparam int unsigned CTRL_IRQ_EN_MATCH = 2;

   localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

endpackage

// File: rtl/port_in_sync.sv
// Two-flop synchronizer for PortIn plus a previous-value flop for change detection.
module port_in_sync #(
   parameter int unsigned IN_WIDTH = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [IN_WIDTH-1:0] pins,
   output logic [IN_WIDTH-1:0] sync_val,
   output logic                changed
);

   logic [IN_WIDTH-1:0] meta_q;
   logic [IN_WIDTH-1:0] sync_q;
   logic [IN_WIDTH-1:0] prev_q;

   // Synchronizer chain and previous-value history
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q <= '0;
         sync_q <= '0;
         prev_q <= '0;
      end else begin
         meta_q <= pins;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign sync_val = sync_q;
   assign changed  = (sync_q != prev_q);

endmodule

// File: rtl/mmio_port_responder.sv
// MMIO responder: output port, synchronized input port, status and compare timer.
module mmio_port_responder #(
   parameter int unsigned      NBits     = 32,
   parameter logic [NBits-1:0] BASE_ADDR = 32'h1001_0040,
   parameter int unsigned      IN_WIDTH  = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                MemWrite,
   input  logic                MemRead,
   input  logic [NBits-1:0]    Address,
   input  logic [NBits-1:0]    WriteData,
   output logic [NBits-1:0]    ReadData,
   output logic                IoHit,
   input  logic [IN_WIDTH-1:0] PortIn,
   output logic [NBits-1:0]    PortOut,
   output logic                Irq
);

   import mmio_pkg::*;

   logic [NBits-1:0]    port_out_q, port_out_d;
   logic [NBits-1:0]    timer_q, timer_d;
   logic [NBits-1:0]    compare_q, compare_d;
   logic [2:0]          ctrl_q, ctrl_d;
   logic [1:0]          status_q, status_d;
   logic [IN_WIDTH-1:0] in_sync;
   logic                in_chg;
   logic [4:0]          offset;
   logic                wr_hit;
   logic                rd_hit;
   logic                tmr_match;
   logic [1:0]          status_set;
   logic [1:0]          status_clr;
   logic                unused_addr_lsb;

   // Byte lanes are not decoded; every access is treated as a full word
   assign unused_addr_lsb = ^Address[1:0];
   assign offset          = {Address[4:2], 2'b00};
   assign IoHit           = (Address[NBits-1:5] == BASE_ADDR[NBits-1:5]);
   assign wr_hit          = MemWrite & IoHit;
   assign rd_hit          = MemRead & IoHit;

   port_in_sync #(
      .IN_WIDTH(IN_WIDTH)
   ) u_port_in_sync (
      .clk     (clk),
      .reset   (reset),
      .pins    (PortIn),
      .sync_val(in_sync),
      .changed (in_chg)
   );

   // Combinational read mux so MEM/WB captures load data in the same cycle
   always_comb begin
      ReadData = '0;
      if (IoHit) begin
         case (offset)
            OFF_PORT_OUT: ReadData = port_out_q;
            OFF_PORT_IN:  ReadData = {{(NBits-IN_WIDTH){1'b0}}, in_sync};
            OFF_STATUS:   ReadData = {{(NBits-2){1'b0}}, status_q};
            OFF_TIMER:    ReadData = timer_q;
            OFF_COMPARE:  ReadData = compare_q;
            OFF_CTRL:     ReadData = {{(NBits-3){1'b0}}, ctrl_q};
            default:      ReadData = '0;
         endcase
      end
   end

   // Next-state for software-visible registers; writes beat increments, sets beat clears
   always_comb begin
      port_out_d = port_out_q;
      compare_d  = compare_q;
      ctrl_d     = ctrl_q;
      timer_d    = timer_q;
      if (ctrl_q[CTRL_TMR_EN]) begin
         timer_d = timer_q + {{(NBits-1){1'b0}}, 1'b1};
      end
      if (wr_hit) begin
         case (offset)
            OFF_PORT_OUT:     port_out_d = WriteData;
            OFF_PORT_OUT_SET: port_out_d = port_out_q | WriteData;
            OFF_PORT_OUT_CLR: port_out_d = port_out_q & ~WriteData;
            OFF_TIMER:        timer_d    = WriteData;
            OFF_COMPARE:      compare_d  = WriteData;
            OFF_CTRL:         ctrl_d     = WriteData[2:0];
            default:          ;
         endcase
      end
      // Match uses the counter value before any same-cycle load
      tmr_match                = ctrl_q[CTRL_TMR_EN] && (timer_q == compare_q);
      status_set               = '0;
      status_set[STS_IN_CHG]    = in_chg;
      status_set[STS_TMR_MATCH] = tmr_match;
      status_clr               = (rd_hit && (offset == OFF_STATUS)) ? 2'b11 : 2'b00;
      status_d                 = (status_q & ~status_clr) | status_set;
   end

   // Register state, asynchronously reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         port_out_q <= '0;
         timer_q    <= '0;
         compare_q  <= NBits'(COMPARE_RST);
         ctrl_q     <= '0;
         status_q   <= '0;
      end else begin
         port_out_q <= port_out_d;
         timer_q    <= timer_d;
         compare_q  <= compare_d;
         ctrl_q     <= ctrl_d;
         status_q   <= status_d;
      end
   end

   assign PortOut = port_out_q;
   assign Irq     = (status_q[STS_IN_CHG] & ctrl_q[CTRL_IRQ_EN_CHG]) |
                    (status_q[STS_TMR_MATCH] & ctrl_q[CTRL_IRQ_EN_MATCH]);

endmodule

// File: tb/tb_mmio_port_responder.sv
// Scoreboard bench: read ops queue expected data, a negedge monitor compares.
module tb_mmio_port_responder;

   localparam logic [31:0] BASE = 32'h1001_0040;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        MemWrite = 1'b0;
   logic        MemRead = 1'b0;
   logic [31:0] Address = BASE;
   logic [31:0] WriteData = '0;
   logic [31:0] ReadData;
   logic        IoHit;
   logic [7:0]  PortIn = '0;
   logic [31:0] PortOut;
   logic        Irq;

   int n_cmp = 0;
   int n_bad = 0;

   string       name_q[$];
   logic [31:0] rd_q[$];
   logic        hit_q[$];

   mmio_port_responder #(
      .NBits    (32),
      .BASE_ADDR(BASE),
      .IN_WIDTH (8)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .MemWrite (MemWrite),
      .MemRead  (MemRead),
      .Address  (Address),
      .WriteData(WriteData),
      .ReadData (ReadData),
      .IoHit    (IoHit),
      .PortIn   (PortIn),
      .PortOut  (PortOut),
      .Irq      (Irq)
   );

   always #5 clk = ~clk;

   // Monitor: every cycle with a load in flight consumes one expected entry
   always @(negedge clk) begin
      if (MemRead) begin
         if (name_q.size() == 0) begin
            n_cmp = n_cmp + 1;
            n_bad = n_bad + 1;
            $display("FAIL unexpected_read: got %h, required no read", ReadData);
         end else begin
            string       nm;
            logic [31:0] er;
            logic        eh;
            nm = name_q.pop_front();
            er = rd_q.pop_front();
            eh = hit_q.pop_front();
            n_cmp = n_cmp + 1;
            if (ReadData !== er || IoHit !== eh) begin
               n_bad = n_bad + 1;
               $display("FAIL %s: got data=%h hit=%b, required data=%h hit=%b",
                        nm, ReadData, IoHit, er, eh);
            end
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      if (act !== exp) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] off, input logic [31:0] d);
      Address   = BASE + off;
      WriteData = d;
      MemWrite  = 1'b1;
      cyc();
      MemWrite  = 1'b0;
   endtask

   task automatic rd_abs(input logic [31:0] a, input logic [31:0] exp, input logic hit,
                         input string nm);
      name_q.push_back(nm);
      rd_q.push_back(exp);
      hit_q.push_back(hit);
      Address = a;
      MemRead = 1'b1;
      cyc();
      MemRead = 1'b0;
   endtask

   task automatic rd(input logic [31:0] off, input logic [31:0] exp, input string nm);
      rd_abs(BASE + off, exp, 1'b1, nm);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset with traffic
      repeat (2) cyc();
      reset = 1'b0;
      cyc();
      wr(32'h00, 32'h11);
      check("port_out_pre_reset", PortOut, 32'h11);
      Address   = BASE;
      WriteData = 32'hA5;
      MemWrite  = 1'b1;
      #2 reset = 1'b1;
      #1;
      check("port_out_async_reset", PortOut, 32'h0);
      check("readdata_async_reset", ReadData, 32'h0);
      check("irq_async_reset", {31'b0, Irq}, 32'h0);
      cyc();
      check("port_out_held_reset", PortOut, 32'h0);
      MemWrite = 1'b0;
      reset    = 1'b0;
      cyc();
      check("port_out_after_release", PortOut, 32'h0);
      rd(32'h00, 32'h0, "rst_port_out");
      rd(32'h0C, 32'h0, "rst_port_in");
      rd(32'h10, 32'h0, "rst_status");
      rd(32'h14, 32'h0, "rst_timer");
      rd(32'h18, 32'hFFFF_FFFF, "rst_compare");
      rd(32'h1C, 32'h0, "rst_ctrl");

      // PORT_OUT set/clear
      wr(32'h00, 32'h0000_00F0);
      check("port_out_write", PortOut, 32'hF0);
      wr(32'h04, 32'h0F);
      check("port_out_set", PortOut, 32'hFF);
      wr(32'h08, 32'h30);
      check("port_out_clr", PortOut, 32'hCF);
      rd(32'h00, 32'hCF, "port_out_readback");
      rd(32'h04, 32'h0, "set_reads_zero");
      rd(32'h08, 32'h0, "clr_reads_zero");

      // PortIn change: two-cycle latency, then IN_CHG
      PortIn = 8'h5A;
      rd(32'h0C, 32'h0, "port_in_lat0");
      rd(32'h0C, 32'h0, "port_in_lat1");
      rd(32'h0C, 32'h5A, "port_in_lat2");
      rd(32'h10, 32'h1, "status_in_chg");
      rd(32'h10, 32'h0, "status_cleared");
      check("irq_chg_masked", {31'b0, Irq}, 32'h0);

      // STATUS read in the same cycle as a set: old value read, set survives
      PortIn = 8'h5B;
      rd(32'h10, 32'h0, "status_race0");
      rd(32'h10, 32'h0, "status_race1");
      rd(32'h10, 32'h0, "status_race_pre_edge");
      rd(32'h10, 32'h1, "status_race_set_wins");
      rd(32'h10, 32'h0, "status_race_clear");

      // Timer compare and interrupt
      wr(32'h18, 32'h5);
      wr(32'h14, 32'h0);
      wr(32'h1C, 32'h5);
      for (int i = 0; i < 5; i++) rd(32'h14, i, "timer_count");
      check("irq_before_match", {31'b0, Irq}, 32'h0);
      rd(32'h14, 32'h5, "timer_at_compare");
      check("irq_on_match", {31'b0, Irq}, 32'h1);
      rd(32'h10, 32'h2, "status_tmr_match");
      check("irq_after_clear", {31'b0, Irq}, 32'h0);
      rd(32'h1C, 32'h5, "ctrl_readback");

      // Timer wrap and load priority
      wr(32'h14, 32'hFFFF_FFFF);
      rd(32'h14, 32'hFFFF_FFFF, "timer_max");
      rd(32'h14, 32'h0, "timer_wrap");
      rd(32'h14, 32'h1, "timer_after_wrap");
      wr(32'h14, 32'h100);
      rd(32'h14, 32'h100, "timer_load_wins");
      rd(32'h14, 32'h101, "timer_load_next");
      wr(32'h1C, 32'h0);
      rd(32'h14, 32'h103, "timer_stopped0");
      rd(32'h14, 32'h103, "timer_stopped1");

      // Simultaneous read and write of PORT_OUT
      Address   = BASE;
      WriteData = 32'h12;
      MemWrite  = 1'b1;
      name_q.push_back("rw_old_value");
      rd_q.push_back(32'hCF);
      hit_q.push_back(1'b1);
      MemRead   = 1'b1;
      cyc();
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      rd(32'h00, 32'h12, "rw_new_value");

      // Boundary decode
      rd_abs(BASE + 32'h20, 32'h0, 1'b0, "miss_above");
      rd_abs(BASE - 32'h4, 32'h0, 1'b0, "miss_below");
      Address   = BASE + 32'h20;
      WriteData = 32'hDEAD;
      MemWrite  = 1'b1;
      cyc();
      Address   = BASE - 32'h4;
      WriteData = 32'hBEEF;
      cyc();
      MemWrite  = 1'b0;
      check("port_out_unchanged", PortOut, 32'h12);
      rd_abs(BASE + 32'h03, 32'h12, 1'b1, "lsb_ignored");
      rd(32'h18, 32'h5, "compare_unchanged");

      cyc();
      check("scoreboard_drained", name_q.size(), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
